// File: rtl/pc_sequencer.sv
// Program counter / fetch sequencer: IDLE/RUN/DONE control, next-pc selection,
// sticky overrun flag and a saturating RUN-cycle counter.
module pc_sequencer #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned LAST_ADDR  = (2 ** PC_W) - 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             jumpFlag,
  input  logic [PC_W-1:0]  jumpTarget,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic             overrun,
  output logic [CNT_W-1:0] cycleCount
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] LAST_PC  = PC_W'(LAST_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovr_q, ovr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      S_RUN: begin
        // Every RUN edge counts, whichever branch below is taken.
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (halt) begin
          state_d = S_DONE;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (jumpFlag) begin
          pc_d = jumpTarget;
        end else if (pc_q == LAST_PC) begin
          state_d = S_DONE;
          ovr_d   = 1'b1;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pc         = pc_q;
  assign running    = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign overrun    = ovr_q;
  assign cycleCount = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default-sized instance (A) and a small
// instance (B: LAST_ADDR=15, CNT_W=4) with independent stimulus.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;

  logic        a_start, a_halt, a_stall, a_jf;
  logic [9:0]  a_jt;
  logic [9:0]  a_pc;
  logic        a_run, a_done, a_ovr;
  logic [15:0] a_cnt;

  logic        b_start, b_halt, b_stall, b_jf;
  logic [9:0]  b_jt;
  logic [9:0]  b_pc;
  logic        b_run, b_done, b_ovr;
  logic [3:0]  b_cnt;

  int unsigned total;
  int unsigned bad;

  pc_sequencer dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (a_start),
    .halt       (a_halt),
    .stall      (a_stall),
    .jumpFlag   (a_jf),
    .jumpTarget (a_jt),
    .pc         (a_pc),
    .running    (a_run),
    .done       (a_done),
    .overrun    (a_ovr),
    .cycleCount (a_cnt)
  );

  pc_sequencer #(
    .PC_W      (10),
    .LAST_ADDR (15),
    .CNT_W     (4)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (b_start),
    .halt       (b_halt),
    .stall      (b_stall),
    .jumpFlag   (b_jf),
    .jumpTarget (b_jt),
    .pc         (b_pc),
    .running    (b_run),
    .done       (b_done),
    .overrun    (b_ovr),
    .cycleCount (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    {a_start, a_halt, a_stall, a_jf} = '0;
    {b_start, b_halt, b_stall, b_jf} = '0;
    a_jt = '0;
    b_jt = '0;

    #12;
    check("rst_a_pc",   32'(a_pc),   32'd0);
    check("rst_a_run",  32'(a_run),  32'd0);
    check("rst_a_done", 32'(a_done), 32'd0);
    check("rst_a_ovr",  32'(a_ovr),  32'd0);
    check("rst_a_cnt",  32'(a_cnt),  32'd0);
    rst_n = 1'b1;

    // Linear fetch from start
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    check("start_pc",  32'(a_pc),  32'd0);
    check("start_run", 32'(a_run), 32'd1);
    check("start_cnt", 32'(a_cnt), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("lin_pc", 32'(a_pc), 32'(i));
    end
    check("lin_cnt", 32'(a_cnt), 32'd5);
    check("lin_run", 32'(a_run), 32'd1);

    // Jump to 3, then stall beats jump, then jump to 0x2A
    a_jf = 1'b1; a_jt = 10'd3;
    step();
    check("jmp3_pc", 32'(a_pc), 32'd3);
    a_stall = 1'b1; a_jt = 10'h2A;
    step();
    check("stall_pc",  32'(a_pc),  32'd3);
    check("stall_cnt", 32'(a_cnt), 32'd7);
    a_stall = 1'b0;
    step();
    check("jmp2a_pc", 32'(a_pc), 32'h2A);
    a_jf = 1'b0;
    step();
    check("inc2b_pc", 32'(a_pc), 32'h2B);
    check("inc2b_cnt", 32'(a_cnt), 32'd9);

    // Halt at 7 wins over a simultaneous jump
    a_jf = 1'b1; a_jt = 10'd7;
    step();
    check("jmp7_pc", 32'(a_pc), 32'd7);
    a_halt = 1'b1; a_jt = 10'h55;
    step();
    check("halt_pc",   32'(a_pc),   32'd7);
    check("halt_done", 32'(a_done), 32'd1);
    check("halt_run",  32'(a_run),  32'd0);
    check("halt_cnt",  32'(a_cnt),  32'd11);
    a_halt = 1'b0;
    step();
    check("done_jmp_pc",  32'(a_pc),  32'd7);
    check("done_jmp_cnt", 32'(a_cnt), 32'd11);
    a_jf = 1'b0;

    // Restart from DONE
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    check("restart_pc",   32'(a_pc),   32'd0);
    check("restart_done", 32'(a_done), 32'd0);
    check("restart_run",  32'(a_run),  32'd1);
    check("restart_cnt",  32'(a_cnt),  32'd0);

    // Async reset mid-RUN at pc=9, asserted between edges
    repeat (9) step();
    check("pre_rst_pc", 32'(a_pc), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc",  32'(a_pc),  32'd0);
    check("arst_run", 32'(a_run), 32'd0);
    check("arst_cnt", 32'(a_cnt), 32'd0);
    #1 rst_n = 1'b1;
    step();
    step();
    check("post_rst_run", 32'(a_run), 32'd0);
    check("post_rst_pc",  32'(a_pc),  32'd0);

    // Instance B: run off the end of a 16-word program
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    repeat (15) step();
    check("b_pc15",  32'(b_pc),  32'd15);
    check("b_run15", 32'(b_run), 32'd1);
    check("b_ovr15", 32'(b_ovr), 32'd0);
    check("b_cnt15", 32'(b_cnt), 32'd15);
    step();
    check("b_ovr_pc",   32'(b_pc),   32'd15);
    check("b_ovr_flag", 32'(b_ovr),  32'd1);
    check("b_ovr_done", 32'(b_done), 32'd1);
    check("b_ovr_cnt",  32'(b_cnt),  32'd15);
    step();
    check("b_ovr_hold", 32'(b_ovr), 32'd1);
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    check("b_rs_ovr", 32'(b_ovr), 32'd0);
    check("b_rs_pc",  32'(b_pc),  32'd0);
    check("b_rs_cnt", 32'(b_cnt), 32'd0);

    // Instance B: counter saturation; start during RUN is ignored
    b_jf = 1'b1; b_jt = 10'd5;
    for (int k = 1; k <= 20; k++) begin
      b_start = (k == 8 || k == 9);
      step();
      check("b_sat_pc", 32'(b_pc), 32'd5);
      if (k == 14) check("b_cnt14", 32'(b_cnt), 32'd14);
    end
    b_start = 1'b0;
    check("b_sat_cnt", 32'(b_cnt), 32'd15);
    check("b_sat_run", 32'(b_run), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
